// File: rtl/noise_estimation_ctrl.sv
// ============================================================================
// Module   : noise_estimation_ctrl
// Purpose  : Frame-level block sequencer and variance reduction (average/min)
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module noise_estimation_ctrl #(
    parameter int VAR_WIDTH     = 16,
    parameter int BLOCK_SAMPLES = 64,
    parameter int BPF_WIDTH     = 16,
    parameter int ACC_WIDTH     = VAR_WIDTH + BPF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_of_frame,
    input  logic                 pixel_valid,
    input  logic                 mean_ready,
    input  logic                 variance_ready,
    input  logic [VAR_WIDTH-1:0] variance_in,
    input  logic [BPF_WIDTH-1:0] blocks_per_frame,
    input  logic                 mode,
    output logic                 shift_en,
    output logic                 shift_reg_clr,
    output logic                 variance_start_of_data,
    output logic [VAR_WIDTH-1:0] noise_est,
    output logic                 noise_valid,
    output logic                 busy,
    output logic [BPF_WIDTH-1:0] block_idx,
    output logic                 overrun
);

    localparam int SC_W = $clog2(BLOCK_SAMPLES);
    localparam int DC_W = $clog2(ACC_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_READ_BLOCK = 3'd1,
        S_WAIT_MEAN  = 3'd2,
        S_WAIT_VAR   = 3'd3,
        S_DIVIDE     = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BPF_WIDTH-1:0] bpf_q;
    logic                 mode_q;
    logic [SC_W-1:0]      sample_cnt;
    logic [ACC_WIDTH-1:0] acc;
    logic [VAR_WIDTH-1:0] min_reg;
    logic [BPF_WIDTH-1:0] rem;
    logic [DC_W-1:0]      div_cnt;
    logic                 vsod_q;
    logic                 overrun_q;

    logic [ACC_WIDTH-1:0] var_ext;
    logic [VAR_WIDTH-1:0] min_next;
    logic                 last_block;
    logic                 last_sample;
    logic                 div_last;
    logic [BPF_WIDTH:0]   rem_shift;
    logic [BPF_WIDTH:0]   rem_diff;
    logic                 rem_ge;
    logic [BPF_WIDTH-1:0] rem_next;
    logic [ACC_WIDTH-1:0] quo_next;

    assign var_ext     = {{(ACC_WIDTH-VAR_WIDTH){1'b0}}, variance_in};
    assign min_next    = (variance_in < min_reg) ? variance_in : min_reg;
    assign last_block  = (({1'b0, block_idx} + (BPF_WIDTH+1)'(1)) == {1'b0, bpf_q});
    assign last_sample = (sample_cnt == SC_W'(BLOCK_SAMPLES-1));
    assign div_last    = (div_cnt == DC_W'(ACC_WIDTH-1));

    // Restoring divider step; acc doubles as the dividend/quotient shift register.
    // A negative trial difference shows up as the borrow in its top bit.
    assign rem_shift = {rem, acc[ACC_WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, bpf_q};
    assign rem_ge    = ~rem_diff[BPF_WIDTH];
    assign rem_next  = rem_ge ? rem_diff[BPF_WIDTH-1:0] : rem_shift[BPF_WIDTH-1:0];
    assign quo_next  = {acc[ACC_WIDTH-2:0], rem_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        shift_en      = 1'b0;
        shift_reg_clr = 1'b0;
        noise_valid   = 1'b0;
        busy          = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                shift_reg_clr = 1'b1;
                if (start_of_frame) begin
                    state_next = (blocks_per_frame == '0) ? S_DONE : S_READ_BLOCK;
                end
            end
            S_READ_BLOCK: begin
                shift_en = pixel_valid;
                if (pixel_valid && last_sample) begin
                    state_next = S_WAIT_MEAN;
                end
            end
            S_WAIT_MEAN: begin
                if (mean_ready) begin
                    state_next = S_WAIT_VAR;
                end
            end
            S_WAIT_VAR: begin
                if (variance_ready) begin
                    if (!last_block) begin
                        state_next = S_READ_BLOCK;
                    end else begin
                        state_next = mode_q ? S_DONE : S_DIVIDE;
                    end
                end
            end
            S_DIVIDE: begin
                if (div_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                noise_valid = 1'b1;
                state_next  = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // noise_est is loaded on the edge entering DONE so it is current while noise_valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bpf_q      <= '0;
            mode_q     <= 1'b0;
            sample_cnt <= '0;
            block_idx  <= '0;
            acc        <= '0;
            min_reg    <= '1;
            rem        <= '0;
            div_cnt    <= '0;
            noise_est  <= '0;
            vsod_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            vsod_q    <= (state == S_WAIT_MEAN) && mean_ready;
            overrun_q <= start_of_frame && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start_of_frame) begin
                        bpf_q      <= blocks_per_frame;
                        mode_q     <= mode;
                        sample_cnt <= '0;
                        block_idx  <= '0;
                        acc        <= '0;
                        min_reg    <= '1;
                        if (blocks_per_frame == '0) begin
                            noise_est <= '0;
                        end
                    end
                end
                S_READ_BLOCK: begin
                    if (pixel_valid) begin
                        sample_cnt <= last_sample ? '0 : sample_cnt + SC_W'(1);
                    end
                end
                S_WAIT_VAR: begin
                    if (variance_ready) begin
                        acc       <= acc + var_ext;
                        min_reg   <= min_next;
                        block_idx <= block_idx + BPF_WIDTH'(1);
                        rem       <= '0;
                        div_cnt   <= '0;
                        if (last_block && mode_q) begin
                            noise_est <= min_next;
                        end
                    end
                end
                S_DIVIDE: begin
                    acc     <= quo_next;
                    rem     <= rem_next;
                    div_cnt <= div_cnt + DC_W'(1);
                    if (div_last) begin
                        noise_est <= quo_next[VAR_WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign variance_start_of_data = vsod_q;
    assign overrun                = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_noise_estimation_ctrl.sv
// ============================================================================
// Module   : tb_noise_estimation_ctrl
// Purpose  : Scoreboard bench for noise_estimation_ctrl with a frame-level model
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_noise_estimation_ctrl;

    localparam int VW = 16;
    localparam int BS = 64;
    localparam int BW = 16;
    localparam int AW = VW + BW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_of_frame = 1'b0;
    logic          pixel_valid = 1'b0;
    logic          mean_ready = 1'b0;
    logic          variance_ready = 1'b0;
    logic [VW-1:0] variance_in = '0;
    logic [BW-1:0] blocks_per_frame = '0;
    logic          mode = 1'b0;
    logic          shift_en;
    logic          shift_reg_clr;
    logic          variance_start_of_data;
    logic [VW-1:0] noise_est;
    logic          noise_valid;
    logic          busy;
    logic [BW-1:0] block_idx;
    logic          overrun;

    noise_estimation_ctrl #(
        .VAR_WIDTH(VW), .BLOCK_SAMPLES(BS), .BPF_WIDTH(BW), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .start_of_frame(start_of_frame),
        .pixel_valid(pixel_valid), .mean_ready(mean_ready),
        .variance_ready(variance_ready), .variance_in(variance_in),
        .blocks_per_frame(blocks_per_frame), .mode(mode),
        .shift_en(shift_en), .shift_reg_clr(shift_reg_clr),
        .variance_start_of_data(variance_start_of_data),
        .noise_est(noise_est), .noise_valid(noise_valid), .busy(busy),
        .block_idx(block_idx), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [VW-1:0] val;
        int            due;
        int            nblk;
    } exp_t;

    exp_t          sbq[$];
    exp_t          e;
    int            nvec = 0;
    int            nerr = 0;
    logic [VW-1:0] vals[0:15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: counts shifts/start pulses and retires scoreboard entries on noise_valid.
    int shifts = 0;
    int vsods  = 0;
    always @(negedge clk) begin
        if (rst) begin
            shifts = 0;
            vsods  = 0;
        end else begin
            if (shift_en) shifts++;
            if (variance_start_of_data) begin
                chk("shifts_per_block", shifts, BS);
                shifts = 0;
                vsods++;
            end
            if (noise_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_noise_valid", noise_valid, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("noise_est", noise_est, e.val);
                    chk("valid_latency_cycle", cyc, e.due);
                    chk("vsod_pulses", vsods, e.nblk);
                    chk("trailing_shifts", shifts, 0);
                end
                vsods  = 0;
                shifts = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set4(input int a, input int b, input int c, input int d);
        vals[0] = VW'(a); vals[1] = VW'(b); vals[2] = VW'(c); vals[3] = VW'(d);
    endtask

    task automatic wait_done();
        for (int t = 0; t < 300 && (sbq.size() != 0 || busy); t++) step();
        chk("frame_drained", sbq.size(), 0);
        chk("idle_after_frame", busy, 0);
        sbq.delete();
    endtask

    task automatic run_frame(input int bpf, input bit md, input bit stall, input bit spur,
                             input bit ovr, input bit sof_done, input int abort_blk);
        longint        sum;
        logic [VW-1:0] mn;
        logic [VW-1:0] expv;
        int            s;
        int            idle;
        bit            ovr_done;
        sum = 0;
        mn  = '1;
        for (int i = 0; i < bpf; i++) begin
            sum += vals[i];
            if (vals[i] < mn) mn = vals[i];
        end
        expv     = (bpf == 0) ? '0 : (md ? mn : VW'(sum / bpf));
        ovr_done = 1'b0;

        start_of_frame   = 1'b1;
        blocks_per_frame = BW'(bpf);
        mode             = md;
        if (bpf == 0) sbq.push_back('{val: '0, due: cyc + 1, nblk: 0});
        step();
        start_of_frame   = 1'b0;
        blocks_per_frame = BW'($urandom);
        mode             = 1'($urandom);

        for (int b = 0; b < bpf; b++) begin
            s = 0;
            while (s < BS) begin
                pixel_valid    = stall ? 1'($urandom) : 1'b1;
                mean_ready     = spur ? ($urandom_range(0, 3) == 0) : 1'b0;
                variance_ready = spur ? ($urandom_range(0, 3) == 0) : 1'b0;
                variance_in    = VW'($urandom);
                if (ovr && b == 0 && s == 10 && !ovr_done) begin
                    start_of_frame = 1'b1;
                    ovr_done = 1'b1;
                end
                #1;
                chk("shift_en_read", shift_en, pixel_valid);
                if (pixel_valid) s++;
                step();
                if (start_of_frame) begin
                    chk("overrun_mid_frame", overrun, 1);
                    start_of_frame = 1'b0;
                end
            end
            pixel_valid    = spur ? 1'($urandom) : 1'b0;
            mean_ready     = 1'b1;
            variance_ready = spur ? 1'($urandom) : 1'b0;
            variance_in    = VW'($urandom);
            #1;
            chk("shift_en_wait_mean", shift_en, 0);
            step();
            mean_ready     = 1'b0;
            variance_ready = 1'b0;
            pixel_valid    = spur ? 1'($urandom) : 1'b0;
            if (b == abort_blk) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_shift_reg_clr", shift_reg_clr, 1);
                chk("rst_noise_est", noise_est, 0);
                chk("rst_block_idx", block_idx, 0);
                chk("rst_vsod", variance_start_of_data, 0);
                step();
                rst = 1'b0;
                pixel_valid = 1'b0;
                return;
            end
            idle = $urandom_range(0, 3);
            repeat (idle) begin
                #1;
                chk("shift_en_wait_var", shift_en, 0);
                step();
                pixel_valid = spur ? 1'($urandom) : 1'b0;
            end
            variance_ready = 1'b1;
            variance_in    = vals[b];
            if (b == bpf - 1)
                sbq.push_back('{val: expv, due: cyc + 1 + (md ? 0 : AW), nblk: bpf});
            step();
            variance_ready = 1'b0;
            variance_in    = VW'($urandom);
            pixel_valid    = 1'b0;
            chk("block_idx", block_idx, b + 1);
        end
        if (sof_done && md && bpf > 0) begin
            start_of_frame   = 1'b1;
            blocks_per_frame = 5;
            step();
            start_of_frame = 1'b0;
            chk("overrun_in_done", overrun, 1);
            chk("done_sof_ignored", busy, 0);
        end
        wait_done();
    endtask

    initial begin
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_shift_reg_clr", shift_reg_clr, 1);
        chk("reset_noise_est", noise_est, 0);
        chk("reset_noise_valid", noise_valid, 0);
        chk("reset_shift_en", shift_en, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_block_idx", block_idx, 0);
        step();
        step();
        rst = 1'b0;
        step();

        set4(10, 20, 30, 40);       run_frame(4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        set4(10, 20, 30, 40);       run_frame(4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        set4(50, 60, 0, 0);         run_frame(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        set4(10, 11, 13, 0);        run_frame(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        set4(7, 8, 0, 0);           run_frame(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        set4('hFFFF, 'hFFFF, 'hFFFF, 'hFFFF);
        run_frame(4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        set4(300, 120, 555, 90);    run_frame(4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        set4(300, 120, 555, 90);    run_frame(3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        set4(1000, 2000, 0, 0);     run_frame(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        set4(1, 2, 3, 4);           run_frame(4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        wait_done();
        set4(5, 9, 14, 21);         run_frame(4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 6; i++) vals[i] = VW'($urandom_range(0, 65535));
            run_frame($urandom_range(1, 6), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'b0, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation exceeded time bound at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
